// File: rtl/decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered MIPS instruction decode stage. Splits the
//               instruction into fields, classifies it (R / I / J / R-jump),
//               extends the immediate, computes branch/jump targets and the
//               write-back register, and holds the result in a valid/ready
//               pipeline register with an optional skid entry.
//               Optional macro: DECODE_ILLEGAL_CHECK_EN (illegal op detection).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int SKID   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [PC_W-1:0]   i_pc,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [5:0]        o_opcode,
    output logic [5:0]        o_funct,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_sa,
    output logic [DATA_W-1:0] o_imm,
    output logic [25:0]       o_addr,
    output logic [1:0]        o_type,
    output logic [4:0]        o_wreg,
    output logic              o_wen,
    output logic [PC_W-1:0]   o_target,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_illegal
);

    localparam logic [1:0] c_TYPE_R  = 2'd0;
    localparam logic [1:0] c_TYPE_I  = 2'd1;
    localparam logic [1:0] c_TYPE_J  = 2'd2;
    localparam logic [1:0] c_TYPE_RJ = 2'd3;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        sa;
        logic [DATA_W-1:0] imm;
        logic [25:0]       addr;
        logic [1:0]        itype;
        logic [4:0]        wreg;
        logic              wen;
        logic [PC_W-1:0]   target;
        logic [PC_W-1:0]   pc;
        logic              illegal;
    } dec_t;

    logic [5:0]      w_op;
    logic [5:0]      w_fn;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_boff;
    logic            w_illegal;
    dec_t            w_dec;

    assign w_op   = i_instr[31:26];
    assign w_fn   = i_instr[5:0];
    assign w_rs   = i_instr[25:21];
    assign w_rt   = i_instr[20:16];
    assign w_rd   = i_instr[15:11];
    assign w_pc4  = i_pc + PC_W'(4);
    assign w_boff = {{(PC_W-18){i_instr[15]}}, i_instr[15:0], 2'b00};

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Flag opcodes / R-type functs outside the supported instruction set
    always_comb begin
        w_illegal = 1'b0;
        if (w_op == 6'h00) begin
            w_illegal = !(w_fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                      6'h08, 6'h09, [6'h20:6'h27], 6'h2A, 6'h2B});
        end else begin
            w_illegal = !(w_op inside {[6'h02:6'h0F], [6'h20:6'h25],
                                      6'h28, 6'h29, 6'h2B});
        end
    end
`else
    assign w_illegal = 1'b0;
`endif

    // Field split, classification, immediate, target and write-back selection
    always_comb begin
        w_dec        = '0;
        w_dec.opcode = w_op;
        w_dec.pc     = i_pc;
        if (w_op == 6'h00 && (w_fn == 6'h08 || w_fn == 6'h09)) begin
            w_dec.itype = c_TYPE_RJ;
            w_dec.funct = w_fn;
            w_dec.rs    = w_rs;
            if (w_fn == 6'h09) begin
                w_dec.rd   = w_rd;
                w_dec.wreg = w_rd;
                w_dec.wen  = |w_rd;
            end
        end else if (w_op == 6'h00) begin
            w_dec.itype = c_TYPE_R;
            w_dec.funct = w_fn;
            w_dec.rs    = w_rs;
            w_dec.rt    = w_rt;
            w_dec.rd    = w_rd;
            w_dec.sa    = i_instr[10:6];
            w_dec.wreg  = w_rd;
            w_dec.wen   = |w_rd;
        end else if (w_op == 6'h02 || w_op == 6'h03) begin
            w_dec.itype  = c_TYPE_J;
            w_dec.addr   = i_instr[25:0];
            // Keep the upper PC bits of pc+4, replace the low 28 with addr<<2
            w_dec.target = (w_pc4 & ~PC_W'(28'hFFF_FFFF)) | PC_W'({i_instr[25:0], 2'b00});
            if (w_op == 6'h03) begin
                w_dec.wreg = 5'd31;
                w_dec.wen  = 1'b1;
            end
        end else begin
            w_dec.itype = c_TYPE_I;
            w_dec.rs    = w_rs;
            w_dec.rt    = w_rt;
            case (w_op)
                6'h0C, 6'h0D, 6'h0E: w_dec.imm = DATA_W'(i_instr[15:0]);
                6'h0F:               w_dec.imm = DATA_W'({i_instr[15:0], 16'h0000});
                default:             w_dec.imm = {{(DATA_W-16){i_instr[15]}}, i_instr[15:0]};
            endcase
            if (w_op inside {[6'h04:6'h07]}) begin
                w_dec.target = w_pc4 + w_boff;
            end
            if (w_op inside {[6'h08:6'h0F], [6'h20:6'h25]}) begin
                w_dec.wreg = w_rt;
                w_dec.wen  = |w_rt;
            end
        end
        w_dec.illegal = w_illegal;
        if (w_illegal) begin
            w_dec.wen = 1'b0;
        end
    end

    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    dec_t out_data_q, out_data_d;
    dec_t skid_data_q, skid_data_d;
    logic w_accept;
    logic w_drain;

    generate
        if (SKID != 0) begin : g_skid_ready
            assign o_ready = !skid_valid_q;
        end else begin : g_comb_ready
            assign o_ready = !out_valid_q || i_ready;
        end
    endgenerate

    assign w_accept = i_valid && o_ready && !i_flush;
    assign w_drain  = out_valid_q && i_ready;

    // Next-state of output register and skid entry; flush wins over everything
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || w_drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                out_valid_d = 1'b1;
                out_data_d  = w_dec;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: only reachable with a skid entry available
            skid_valid_d = 1'b1;
            skid_data_d  = w_dec;
        end
    end

    // Pipeline registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_opcode  = out_data_q.opcode;
    assign o_funct   = out_data_q.funct;
    assign o_rs      = out_data_q.rs;
    assign o_rt      = out_data_q.rt;
    assign o_rd      = out_data_q.rd;
    assign o_sa      = out_data_q.sa;
    assign o_imm     = out_data_q.imm;
    assign o_addr    = out_data_q.addr;
    assign o_type    = out_data_q.itype;
    assign o_wreg    = out_data_q.wreg;
    assign o_wen     = out_data_q.wen;
    assign o_target  = out_data_q.target;
    assign o_pc      = out_data_q.pc;
    assign o_illegal = out_data_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Scoreboard bench for decode_stage (SKID=1, 32-bit widths).
//               Directed test-plan cases followed by randomized traffic with
//               random backpressure and flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_flush;
    logic [31:0] i_instr, i_pc;
    logic        o_ready, o_valid, o_wen, o_illegal;
    logic [5:0]  o_opcode, o_funct;
    logic [4:0]  o_rs, o_rt, o_rd, o_sa, o_wreg;
    logic [31:0] o_imm, o_target, o_pc;
    logic [25:0] o_addr;
    logic [1:0]  o_type;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .PC_W(32), .SKID(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_opcode(o_opcode), .o_funct(o_funct), .o_rs(o_rs),
        .o_rt(o_rt), .o_rd(o_rd), .o_sa(o_sa), .o_imm(o_imm), .o_addr(o_addr),
        .o_type(o_type), .o_wreg(o_wreg), .o_wen(o_wen), .o_target(o_target),
        .o_pc(o_pc), .o_illegal(o_illegal)
    );

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd, sa;
        logic [31:0] imm;
        logic [25:0] addr;
        logic [1:0]  typ;
        logic [4:0]  wreg;
        logic        wen;
        logic [31:0] target;
        logic [31:0] pc;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference decode, straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        int unsigned op, fn;
        int          simm;
        e    = '0;
        op   = ins[31:26];
        fn   = ins[5:0];
        simm = int'($signed(ins[15:0]));
        e.opcode = ins[31:26];
        e.pc     = pc;
        if (op == 0 && (fn == 8 || fn == 9)) begin
            e.typ = 2'd3; e.funct = ins[5:0]; e.rs = ins[25:21];
            if (fn == 9) begin
                e.rd = ins[15:11]; e.wreg = ins[15:11]; e.wen = (ins[15:11] != 0);
            end
        end else if (op == 0) begin
            e.typ = 2'd0; e.funct = ins[5:0]; e.rs = ins[25:21]; e.rt = ins[20:16];
            e.rd = ins[15:11]; e.sa = ins[10:6];
            e.wreg = ins[15:11]; e.wen = (ins[15:11] != 0);
        end else if (op == 2 || op == 3) begin
            e.typ    = 2'd2;
            e.addr   = ins[25:0];
            e.target = ((pc + 32'd4) & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
            if (op == 3) begin e.wreg = 5'd31; e.wen = 1'b1; end
        end else begin
            e.typ = 2'd1; e.rs = ins[25:21]; e.rt = ins[20:16];
            if (op >= 12 && op <= 14)  e.imm = 32'(ins[15:0]);
            else if (op == 15)         e.imm = 32'(ins[15:0]) * 32'd65536;
            else                       e.imm = 32'(simm);
            if (op >= 4 && op <= 7)    e.target = pc + 32'd4 + 32'(simm * 4);
            if ((op >= 8 && op <= 15) || (op >= 32 && op <= 37)) begin
                e.wreg = ins[20:16]; e.wen = (ins[20:16] != 0);
            end
        end
`ifdef DECODE_ILLEGAL_CHECK_EN
        if (op == 0)
            e.illegal = !(fn == 0 || fn == 2 || fn == 3 || fn == 4 || fn == 6 || fn == 7 ||
                          fn == 8 || fn == 9 || (fn >= 32 && fn <= 39) || fn == 42 || fn == 43);
        else
            e.illegal = !((op >= 2 && op <= 15) || (op >= 32 && op <= 37) ||
                          op == 40 || op == 41 || op == 43);
        if (e.illegal) e.wen = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t grab();
        exp_t g;
        g.opcode = o_opcode; g.funct = o_funct; g.rs = o_rs; g.rt = o_rt;
        g.rd = o_rd; g.sa = o_sa; g.imm = o_imm; g.addr = o_addr; g.typ = o_type;
        g.wreg = o_wreg; g.wen = o_wen; g.target = o_target; g.pc = o_pc;
        g.illegal = o_illegal;
        return g;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        ins = $urandom;
        k   = $urandom_range(0, 9);
        case (k)
            0: ins[31:26] = 6'h00;
            1: begin ins[31:26] = 6'h00; ins[5:0] = ($urandom_range(0, 1) != 0) ? 6'h08 : 6'h09; end
            2: ins[31:26] = 6'($urandom_range(2, 3));
            3: ins[31:26] = 6'($urandom_range(4, 7));
            4: ins[31:26] = 6'($urandom_range(8, 15));
            5: ins[31:26] = 6'($urandom_range(32, 37));
            8: ins[31:26] = 6'h0F;
            9: ins[31:26] = ($urandom_range(0, 1) != 0) ? 6'h28 : 6'h2B;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) ins[20:16] = 5'd0;
        if ($urandom_range(0, 3) == 0) ins[15:11] = 5'd0;
        return ins;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and record the expectation
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        @(negedge clk);
        i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
        #2;
        if (rst || fl)          q.delete();
        else if (v && o_ready)  q.push_back(model(ins, pc));
    endtask

    // Monitor: output must always equal the head of the expected queue
    initial begin
        exp_t g;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                total++;
                if (o_valid !== (q.size() != 0)) begin
                    bad++;
                    $display("FAIL valid got=%0b exp=%0b", o_valid, (q.size() != 0));
                end
                total++;
                if (o_ready !== (q.size() < 2)) begin
                    bad++;
                    $display("FAIL ready got=%0b exp=%0b", o_ready, (q.size() < 2));
                end
                if (o_valid && q.size() != 0) begin
                    g = grab();
                    total++;
                    if (g !== q[0]) begin
                        bad++;
                        $display("FAIL fields got=%h exp=%h", g, q[0]);
                    end
                    if (i_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
        i_instr = '0; i_pc = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_imm", 64'(o_imm), 64'd0);
        chk("rst_pc", 64'(o_pc), 64'd0);
        chk("rst_target", 64'(o_target), 64'd0);
        chk("rst_wen", 64'(o_wen), 64'd0);
        @(negedge clk); rst = 1'b0;
        cycle(0, 0, 0, 1, 0);
        chk("ready_after_rst", 64'(o_ready), 64'd1);

        // ADD $8,$9,$10
        cycle(1, 32'h012A_4020, 32'h0000_1000, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("add_valid", 64'(o_valid), 64'd1);
        chk("add_type", 64'(o_type), 64'd0);
        chk("add_rs", 64'(o_rs), 64'd9);
        chk("add_rt", 64'(o_rt), 64'd10);
        chk("add_wreg", 64'(o_wreg), 64'd8);
        chk("add_wen", 64'(o_wen), 64'd1);
        chk("add_imm", 64'(o_imm), 64'd0);
        // ADDI / ORI / LUI
        cycle(1, 32'h2128_FFFF, 32'h0000_2000, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("addi_imm", 64'(o_imm), 64'hFFFF_FFFF);
        chk("addi_wreg", 64'(o_wreg), 64'd8);
        cycle(1, 32'h3528_FFFF, 32'h0000_2004, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("ori_imm", 64'(o_imm), 64'h0000_FFFF);
        cycle(1, 32'h3C08_1234, 32'h0000_2008, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("lui_imm", 64'(o_imm), 64'h1234_0000);
        // BEQ, JAL, JR
        cycle(1, 32'h1109_FFFF, 32'h0000_0100, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("beq_target", 64'(o_target), 64'h0000_0100);
        cycle(1, 32'h0C00_0010, 32'h0040_0000, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("jal_target", 64'(o_target), 64'h0000_0040);
        chk("jal_wreg", 64'(o_wreg), 64'd31);
        cycle(1, 32'h03E0_0008, 32'h0000_3000, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("jr_type", 64'(o_type), 64'd3);
        chk("jr_rs", 64'(o_rs), 64'd31);
        chk("jr_rt_rd", 64'({o_rt, o_rd, o_sa}), 64'd0);
        chk("jr_wen", 64'(o_wen), 64'd0);

        // Backpressure: 4 offered, only 2 taken
        cycle(1, 32'h012A_4020, 32'h10, 0, 0);
        cycle(1, 32'h2128_0005, 32'h14, 0, 0);
        cycle(1, 32'h3528_0006, 32'h18, 0, 0);
        chk("bp_ready_low", 64'(o_ready), 64'd0);
        cycle(1, 32'h3C08_0007, 32'h1C, 0, 0);
        chk("bp_ready_still_low", 64'(o_ready), 64'd0);
        cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("bp_drained_valid", 64'(o_valid), 64'd0);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // Flush with both entries full and a simultaneous incoming instruction
        cycle(1, 32'h012A_4020, 32'h20, 0, 0);
        cycle(1, 32'h2128_0001, 32'h24, 0, 0);
        cycle(1, 32'h2128_0002, 32'h28, 0, 1);
        cycle(0, 0, 0, 1, 0);
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        // Flush overriding an accept while ready
        cycle(1, 32'h2128_0003, 32'h30, 0, 0);
        cycle(1, 32'h2128_0004, 32'h34, 0, 1);
        cycle(0, 0, 0, 1, 0);
        chk("flush_accept_valid", 64'(o_valid), 64'd0);

        // Asynchronous reset while stalled
        cycle(1, 32'h012A_4020, 32'h40, 0, 0);
        cycle(1, 32'h2128_0009, 32'h44, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("stall_valid_pre", 64'(o_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_pc", 64'(o_pc), 64'd0);
        q.delete();
        cycle(0, 0, 0, 1, 0);
        @(negedge clk); rst = 1'b0;
        cycle(0, 0, 0, 1, 0);
        chk("arst_ready", 64'(o_ready), 64'd1);

`ifdef DECODE_ILLEGAL_CHECK_EN
        cycle(1, 32'hFD28_0001, 32'h50, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("illegal_op", 64'(o_illegal), 64'd1);
        chk("illegal_wen", 64'(o_wen), 64'd0);
        cycle(1, 32'h012A_4001, 32'h54, 1, 0); cycle(0, 0, 0, 1, 0);
        chk("illegal_funct", 64'(o_illegal), 64'd1);
`endif

        // Randomized traffic with backpressure and occasional flushes
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cycle($urandom_range(0, 9) < 7, rand_instr(), pc,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end
        for (int n = 0; n < 4; n++) cycle(0, 0, 0, 1, 0);
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        chk("final_valid", 64'(o_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
